retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//  Synthesizable, parametrised retire-trace capture for RISCV_Processor; replaces per-cycle bench $display monitoring.
//  Records {pc, instr, rd, wdata} for each retired instruction into a circular buffer.
//  Supports wrap or stop-on-full capture and a PC-match trigger with programmable post-trigger depth.
//  Frozen trace drains oldest-first over a valid/ready port; sits beside the core's writeback stage.
// PARAMETERS
//  XLEN   32  width of pc and writeback data
//  DEPTH  16  trace entries; power of two, >=2
//  CW     $clog2(DEPTH)+1  width of count/post-count (derived, localparam)
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset, synchronous, active-low
//  ret_valid     in   1     one instruction retires this cycle
//  ret_pc        in   XLEN  pc of retiring instruction
//  ret_instr     in   32    instruction word
//  ret_rd        in   5     destination register index
//  ret_wdata     in   XLEN  writeback value
//  cfg_mode      in   1     0=wrap (keep newest DEPTH), 1=stop when full
//  cfg_trig_en   in   1     enable PC-match trigger
//  cfg_trig_pc   in   XLEN  trigger pc
//  cfg_post_cnt  in   CW    records to capture after trigger record (0..DEPTH)
//  arm           in   1     pulse: clear buffer, start capture
//  rd_ready      in   1     consumer accepts head record
//  rd_valid      out  1     head record valid
//  rd_pc/rd_instr/rd_rd/rd_wdata  out  XLEN/32/5/XLEN  head record
//  state         out  2     0=IDLE 1=ARMED 2=POST 3=DONE
//  count         out  CW    stored records (0..DEPTH)
//  overflow      out  1     sticky: records lost since arm
//  retire_cnt    out  32    total retirements since reset, wraps at 2^32
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, count=0, wr/rd ptr=0, overflow=0, retire_cnt=0, rd_valid=0. Trace RAM not cleared.
//  - Reset mid-capture or mid-drain aborts it; no record survives as readable.
//  - retire_cnt +1 on every ret_valid in every state.
//  - arm (any state): next cycle state=ARMED, count=0, wr_ptr=0, overflow=0; same-cycle ret_valid not captured (arm wins).
//  - ARMED/POST, ret_valid: record written at wr_ptr; wr_ptr+1 mod DEPTH; count+1, visible next cycle.
//  - Full (count==DEPTH) on write, mode 0: overwrite oldest; count stays DEPTH; overflow=1.
//  - Full on write, mode 1: record dropped; overflow=1; state->DONE.
//  - Trigger in ARMED: cfg_trig_en & ret_valid & ret_pc==cfg_trig_pc; triggering record written.
//    post_cnt==0 -> DONE, else POST with remain=cfg_post_cnt (sampled at trigger).
//  - POST: each captured record decrements remain; remain hits 0 -> DONE next cycle. Trigger ignored.
//  - Mode 1 full + trigger same cycle: full rule wins (record dropped, DONE).
//  - DONE: ret_valid ignored (retire_cnt still counts). rd_valid = count!=0.
//    Head = mem[(wr_ptr-count) mod DEPTH], combinational from registered pointers.
//    rd_valid & rd_ready pops: count-1. count==0 in DONE -> IDLE next cycle.
//  - IDLE/ARMED/POST: rd_valid=0; rd_ready ignored.
//  - rd_* outputs don't-care while rd_valid=0.
// TESTING
//  1 Reset: rst=0 two cycles -> state=0, count=0, overflow=0, retire_cnt=0, rd_valid=0.
//  2 DEPTH=16, mode0, trig pc=0x40, post=3.
//    Retire pcs 0x00..0x7C step 4 (32 instr) -> DONE after pc 0x4C.
//    count=16, overflow=1, drain pcs 0x10..0x4C in order; then IDLE.
//  3 mode1, trig off, 20 retires -> DONE after 17th.
//    count=16, overflow=1, drain first 16 records; retire_cnt=20.
//  4 arm asserted with ret_valid same cycle -> that record absent, count=0 next cycle.
//  5 Drain with rd_ready toggling 1,0,1 -> exactly one pop per accepted cycle; head stable while rd_ready=0.
//  6 rst=0 during POST with count=5 -> IDLE, count=0, rd_valid=0, no drain possible.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
// Captures one {pc, instr, rd, wdata} record per retired instruction into a
// circular trace RAM. Capture can wrap (keep the newest DEPTH records) or stop
// when full. An optional PC-match trigger ends capture after a programmable
// number of further records. The frozen trace then drains oldest-first over a
// valid/ready port, and the block returns to IDLE once the trace is empty.

module retire_trace_buffer #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,

    // Retire port from the writeback stage
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [31:0]     ret_instr,
    input  logic [4:0]      ret_rd,
    input  logic [XLEN-1:0] ret_wdata,

    // Capture configuration
    input  logic            cfg_mode,
    input  logic            cfg_trig_en,
    input  logic [XLEN-1:0] cfg_trig_pc,
    input  logic [CW-1:0]   cfg_post_cnt,
    input  logic            arm,

    // Drain port
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic [4:0]      rd_rd,
    output logic [XLEN-1:0] rd_wdata,

    // Status
    output logic [1:0]      state,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic [31:0]     retire_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Trace RAM, one array per record field
    logic [XLEN-1:0] r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];
    logic [4:0]      r_mem_rd    [DEPTH];
    logic [XLEN-1:0] r_mem_wdata [DEPTH];

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_remain;
    logic            r_overflow;
    logic [31:0]     r_retire_cnt;

    logic            w_full;
    logic            w_capturing;
    logic            w_trig_hit;
    logic            w_drop;
    logic            w_write;
    logic            w_rd_valid;
    logic            w_pop;
    logic [AW-1:0]   w_head_idx;

    // Capture / drain decode, all derived from registered state
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_trig_hit  = cfg_trig_en && ret_valid && (ret_pc == cfg_trig_pc);
    // Stop-on-full: the record that finds the buffer full is discarded.
    assign w_drop      = w_capturing && ret_valid && cfg_mode && w_full && !arm;
    // arm takes priority over a same-cycle retirement.
    assign w_write     = w_capturing && ret_valid && !w_drop && !arm;
    assign w_rd_valid  = (r_state == S_DONE) && (r_count != '0);
    assign w_pop       = w_rd_valid && rd_ready;
    // Oldest record sits count entries behind the write pointer; when full the
    // low bits of count are zero and the head equals the write pointer.
    assign w_head_idx  = r_wr_ptr - r_count[AW-1:0];

    // Trace RAM write port
    // NOTE: the trace RAM has no reset; validity is tracked by r_count alone,
    // so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (rst && w_write) begin
            r_mem_pc[r_wr_ptr]    <= ret_pc;
            r_mem_instr[r_wr_ptr] <= ret_instr;
            r_mem_rd[r_wr_ptr]    <= ret_rd;
            r_mem_wdata[r_wr_ptr] <= ret_wdata;
        end
    end

    // Free-running retirement counter, independent of capture state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (ret_valid) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    // Capture / trigger / drain state machine with pointer and count upkeep
    // NOTE: reset is synchronous and active-low, so it is sampled inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_remain   <= '0;
            r_overflow <= 1'b0;
        end else if (arm) begin
            r_state    <= S_ARMED;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_remain   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_ARMED, S_POST: begin
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (w_write) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end

                        if (r_state == S_ARMED) begin
                            if (w_trig_hit) begin
                                if (cfg_post_cnt == '0) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_state  <= S_POST;
                                    r_remain <= cfg_post_cnt;
                                end
                            end
                        end else begin
                            r_remain <= r_remain - CW'(1);
                            if (r_remain == CW'(1)) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                    end else if (w_pop) begin
                        r_count <= r_count - CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Head record and status outputs
    assign rd_valid   = w_rd_valid;
    assign rd_pc      = r_mem_pc[w_head_idx];
    assign rd_instr   = r_mem_instr[w_head_idx];
    assign rd_rd      = r_mem_rd[w_head_idx];
    assign rd_wdata   = r_mem_wdata[w_head_idx];
    assign state      = r_state;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer
// Directed bench for retire_trace_buffer: wrap capture with trigger, stop on
// full, arm/retire collision, throttled drain and reset during POST.

module tb_retire_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic [31:0]     ret_instr;
    logic [4:0]      ret_rd;
    logic [XLEN-1:0] ret_wdata;
    logic            cfg_mode;
    logic            cfg_trig_en;
    logic [XLEN-1:0] cfg_trig_pc;
    logic [CW-1:0]   cfg_post_cnt;
    logic            arm;
    logic            rd_ready;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_wdata;
    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [31:0]     retire_cnt;

    int checks;
    int errors;

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_instr    (ret_instr),
        .ret_rd       (ret_rd),
        .ret_wdata    (ret_wdata),
        .cfg_mode     (cfg_mode),
        .cfg_trig_en  (cfg_trig_en),
        .cfg_trig_pc  (cfg_trig_pc),
        .cfg_post_cnt (cfg_post_cnt),
        .arm          (arm),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_rd        (rd_rd),
        .rd_wdata     (rd_wdata),
        .state        (state),
        .count        (count),
        .overflow     (overflow),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record fields are pure functions of the pc so the bench can predict them
    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return {16'hA5C3, pc[15:0]};
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        ret_valid = 1'b1;
        ret_pc    = pc;
        ret_instr = f_instr(pc);
        ret_rd    = f_rd(pc);
        ret_wdata = f_wdata(pc);
        step();
        ret_valid = 1'b0;
    endtask

    // Pop n records with rd_ready held high, expecting consecutive pcs
    task automatic drain(input string tag, input logic [31:0] first_pc, input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = first_pc + 32'(4 * k);
            check({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
            check({tag, " count"},    64'(count),    64'(n - k));
            check({tag, " rd_pc"},    64'(rd_pc),    64'(pc));
            check({tag, " rd_instr"}, 64'(rd_instr), 64'(f_instr(pc)));
            check({tag, " rd_rd"},    64'(rd_rd),    64'(f_rd(pc)));
            check({tag, " rd_wdata"}, 64'(rd_wdata), 64'(f_wdata(pc)));
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        check({tag, " empty rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, " empty count"},    64'(count),    64'd0);
        step();
        check({tag, " idle after drain"}, 64'(state), 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        ret_valid    = 1'b0;
        ret_pc       = '0;
        ret_instr    = '0;
        ret_rd       = '0;
        ret_wdata    = '0;
        cfg_mode     = 1'b0;
        cfg_trig_en  = 1'b0;
        cfg_trig_pc  = '0;
        cfg_post_cnt = '0;
        arm          = 1'b0;
        rd_ready     = 1'b0;

        // 1: reset state
        do_reset();
        check("rst state",      64'(state),      64'd0);
        check("rst count",      64'(count),      64'd0);
        check("rst overflow",   64'(overflow),   64'd0);
        check("rst retire_cnt", 64'(retire_cnt), 64'd0);
        check("rst rd_valid",   64'(rd_valid),   64'd0);

        // 2: wrap mode, trigger at 0x40 with three post-trigger records
        cfg_mode     = 1'b0;
        cfg_trig_en  = 1'b1;
        cfg_trig_pc  = 32'h40;
        cfg_post_cnt = CW'(3);
        do_arm();
        check("t2 armed", 64'(state), 64'd1);
        check("t2 count0", 64'(count), 64'd0);
        for (int i = 0; i < 32; i++) begin
            retire(32'(i * 4));
            if (i == 15) check("t2 full count", 64'(count), 64'd16);
            if (i == 15) check("t2 no ovf yet", 64'(overflow), 64'd0);
            if (i == 16) check("t2 post", 64'(state), 64'd2);
            if (i == 18) check("t2 still post", 64'(state), 64'd2);
            if (i == 19) check("t2 done", 64'(state), 64'd3);
        end
        check("t2 count",      64'(count),      64'd16);
        check("t2 overflow",   64'(overflow),   64'd1);
        check("t2 retire_cnt", 64'(retire_cnt), 64'd32);
        drain("t2", 32'h10, 16);

        // 3: stop-on-full, no trigger, 20 retirements
        do_reset();
        cfg_mode    = 1'b1;
        cfg_trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 20; i++) begin
            retire(32'h100 + 32'(i * 4));
            if (i == 15) check("t3 armed at 16", 64'(state), 64'd1);
            if (i == 16) check("t3 done at 17", 64'(state), 64'd3);
        end
        check("t3 count",      64'(count),      64'd16);
        check("t3 overflow",   64'(overflow),   64'd1);
        check("t3 retire_cnt", 64'(retire_cnt), 64'd20);
        drain("t3", 32'h100, 16);

        // 4: arm with a same-cycle retirement; trigger with zero post depth
        cfg_mode     = 1'b0;
        cfg_trig_en  = 1'b1;
        cfg_trig_pc  = 32'h204;
        cfg_post_cnt = '0;
        arm       = 1'b1;
        ret_valid = 1'b1;
        ret_pc    = 32'h200;
        ret_instr = f_instr(32'h200);
        ret_rd    = f_rd(32'h200);
        ret_wdata = f_wdata(32'h200);
        step();
        arm       = 1'b0;
        ret_valid = 1'b0;
        check("t4 armed",      64'(state),      64'd1);
        check("t4 count0",     64'(count),      64'd0);
        check("t4 retire_cnt", 64'(retire_cnt), 64'd21);
        retire(32'h204);
        check("t4 done", 64'(state), 64'd3);
        drain("t4", 32'h204, 1);

        // 5: rd_ready ignored while armed, then throttled drain
        cfg_trig_pc = 32'h308;
        do_arm();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("t5 armed ready ignored", 64'(count), 64'd0);
        check("t5 armed rd_valid", 64'(rd_valid), 64'd0);
        retire(32'h300);
        retire(32'h304);
        retire(32'h308);
        check("t5 done",  64'(state), 64'd3);
        check("t5 count", 64'(count), 64'd3);
        check("t5 head0", 64'(rd_pc), 64'h300);
        rd_ready = 1'b1;
        step();
        check("t5 pop1 count", 64'(count), 64'd2);
        check("t5 pop1 head",  64'(rd_pc), 64'h304);
        rd_ready = 1'b0;
        step();
        check("t5 hold count", 64'(count), 64'd2);
        check("t5 hold head",  64'(rd_pc), 64'h304);
        rd_ready = 1'b1;
        step();
        check("t5 pop2 count", 64'(count), 64'd1);
        check("t5 pop2 head",  64'(rd_pc), 64'h308);
        rd_ready = 1'b0;
        drain("t5", 32'h308, 1);

        // 6: reset during POST with five records stored
        cfg_trig_pc  = 32'h500;
        cfg_post_cnt = CW'(8);
        do_arm();
        for (int i = 0; i < 5; i++) retire(32'h4F0 + 32'(i * 4));
        check("t6 post",  64'(state), 64'd2);
        check("t6 count", 64'(count), 64'd5);
        do_reset();
        check("t6 idle",       64'(state),      64'd0);
        check("t6 count0",     64'(count),      64'd0);
        check("t6 rd_valid",   64'(rd_valid),   64'd0);
        check("t6 overflow",   64'(overflow),   64'd0);
        check("t6 retire_cnt", 64'(retire_cnt), 64'd0);
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        check("t6 no drain valid", 64'(rd_valid), 64'd0);
        check("t6 no drain state", 64'(state),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
